mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one instruction/data memory port (valid/ready request channel, valid/ready response channel) between two requesters: port 0 = data load/store unit, port 1 = instruction fetch.
- Sits between the CPU core and the single memory/ROM model.
- Allows one outstanding transaction; arbitrates ties round-robin or fixed priority; routes each response back to the requester that issued it.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RR_EN, 1, 1 = round-robin on ties; 0 = fixed priority, port 0 always wins

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  2  per-port request valid (bit n = port n)
req_ready  output  2  per-port request accepted
req_addr0 / req_addr1  input  ADDR_W  per-port byte address
req_we  input  2  per-port write enable (0 = read)
req_wdata0 / req_wdata1  input  DATA_W  per-port write data
resp_valid  output  2  per-port response valid
resp_ready  input  2  per-port response accept
resp_data  output  DATA_W  response data, shared by both ports; qualify with resp_valid
mem_req_valid  output  1  downstream request valid
mem_req_ready  input  1  downstream request accept
mem_req_addr  output  ADDR_W  latched address
mem_req_we  output  1  latched write enable
mem_req_wdata  output  DATA_W  latched write data
mem_resp_valid  input  1  downstream response valid (reads and write acks)
mem_resp_ready  output  1  downstream response accept
mem_resp_data  input  DATA_W  downstream response data
busy  output  1  high when state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset (sampled at posedge clk):
  - State = IDLE, owner = 0, last_grant = 1, so port 0 wins the first tie.
  - All outputs 0, including req_ready, resp_valid, mem_req_valid, mem_resp_ready and busy.
  - mem_req_addr, mem_req_we, mem_req_wdata = 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - grant is combinational from req_valid.
  - Exactly one requester valid -> it wins.
  - Both valid and RR_EN = 1 -> the port != last_grant wins.
  - Both valid and RR_EN = 0 -> port 0 wins.
  - req_ready[winner] = 1 in this same cycle; the other port's req_ready = 0.
  - On the handshake, latch addr/we/wdata and owner = winner, then go to ISSUE.
  - No request valid -> stay in IDLE.
- ISSUE:
  - mem_req_valid = 1, driven from the latched registers only.
  - Registers remain stable while mem_req_ready = 0.
  - On mem_req_valid && mem_req_ready -> go to WAIT.
  - req_ready = 0 on both ports.
- WAIT:
  - resp_valid[owner] = mem_resp_valid; resp_valid[other] = 0.
  - resp_data = mem_resp_data; mem_resp_ready = resp_ready[owner].
  - On mem_resp_valid && resp_ready[owner]: last_grant = owner, go to IDLE.
- Latency: request accept to mem_req_valid = 1 cycle. Minimum accept-to-accept = 3 cycles (IDLE, ISSUE, WAIT), with zero-wait memory.
- Response path is combinational pass-through; no response buffering.
- mem_resp_ready = 0 outside WAIT. mem_resp_valid outside WAIT is ignored and never forwarded.
- Requester changing or dropping req_valid without a handshake: no effect, since state is only latched on handshake.
- New requests are not accepted until the current response completes. The other port's req_valid must hold; req_ready stays 0.
- resp_ready deasserted in WAIT: hold in WAIT indefinitely; no timeout.
- Reset mid-transaction: abort immediately to IDLE. The memory model is reset by the same reset, so no stale response is expected.
- Write requests complete on the mem_resp_valid ack exactly like reads; resp_data is don't-care for writes.
- busy = (state != IDLE).

Test Plan:
- Single read, port 1, addr 0x00000008, memory returns 0x00000013 after 1 cycle -> req_ready[1] pulses once; mem_req_addr = 0x8 one cycle later; resp_valid[1] = 1 with resp_data = 0x13; resp_valid[0] stays 0.
- Both ports valid from reset, RR_EN = 1, addr0 = 0x100, addr1 = 0x4 -> grant order port 0, port 1, port 0, port 1; mem_req_addr sequence 0x100, 0x4, 0x100, 0x4.
- Same stimulus with RR_EN = 0 -> port 0 granted every transaction; port 1 req_ready never asserts while port 0 stays valid.
- Backpressure: mem_req_ready low for 3 cycles during ISSUE -> mem_req_addr/we/wdata stable for all 4 cycles; exactly one downstream handshake.
- Port 0 write, wdata 0xDEADBEEF to 0x200, resp_ready[0] low for 2 cycles -> mem_req_we = 1, mem_req_wdata = 0xDEADBEEF; mem_resp_ready low for 2 cycles; busy remains 1 until the ack handshake.
- Reset asserted in WAIT with a pending read -> next cycle busy = 0, all valids 0; first tie after reset is granted to port 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one valid/ready memory port (port 0 = load/store, port 1 = fetch).
// One transaction in flight; the response is passed straight through to the port that issued it.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [1:0]        req_we,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                grant_s;

    // Winner selection; on a tie round-robin favours the port not served last.
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = (RR_EN != 0) ? ~last_grant_q : 1'b0;
            default: grant_s = 1'b0;
        endcase
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        req_ready      = 2'b00;
        resp_valid     = 2'b00;
        mem_resp_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready[grant_s] = 1'b1;
                    owner_d            = grant_s;
                    addr_d             = grant_s ? req_addr1 : req_addr0;
                    we_d               = req_we[grant_s];
                    wdata_d            = grant_s ? req_wdata1 : req_wdata0;
                    state_d            = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                // Only the owner sees the response; a stalled owner holds us here.
                resp_valid[owner_q] = mem_resp_valid;
                mem_resp_ready      = resp_ready[owner_q];
                if (mem_resp_valid && resp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign resp_data     = (state_q == WAIT) ? mem_resp_data : {DATA_W{1'b0}};
    assign busy          = (state_q != IDLE);

    // State and request latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= {ADDR_W{1'b0}};
            we_q         <= 1'b0;
            wdata_q      <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share the same stimulus
// and are each checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_we, resp_ready;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1, mem_resp_data;
    logic        mem_req_ready, mem_resp_valid;

    logic [1:0]  d_req_ready [2];
    logic [1:0]  d_resp_valid [2];
    logic [31:0] d_resp_data [2];
    logic        d_mem_req_valid [2];
    logic [31:0] d_mem_req_addr [2];
    logic        d_mem_req_we [2];
    logic [31:0] d_mem_req_wdata [2];
    logic        d_mem_resp_ready [2];
    logic        d_busy [2];

    int checks = 0;
    int failures = 0;

    // Model: phase 0 = free, 1 = request presented downstream, 2 = awaiting response
    int          m_phase [2] = '{0, 0};
    bit          m_owner [2] = '{1'b0, 1'b0};
    bit          m_last  [2] = '{1'b1, 1'b1};
    logic [31:0] m_addr  [2] = '{32'h0, 32'h0};
    logic [31:0] m_wdata [2] = '{32'h0, 32'h0};
    bit          m_we    [2] = '{1'b0, 1'b0};

    int          gq0[$], gq1[$];
    logic [31:0] aq0[$], aq1[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) u_rr (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_req_ready[0]),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_we(req_we),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .resp_valid(d_resp_valid[0]),
        .resp_ready(resp_ready), .resp_data(d_resp_data[0]), .mem_req_valid(d_mem_req_valid[0]),
        .mem_req_ready(mem_req_ready), .mem_req_addr(d_mem_req_addr[0]), .mem_req_we(d_mem_req_we[0]),
        .mem_req_wdata(d_mem_req_wdata[0]), .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(d_mem_resp_ready[0]), .mem_resp_data(mem_resp_data), .busy(d_busy[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) u_fp (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_req_ready[1]),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_we(req_we),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .resp_valid(d_resp_valid[1]),
        .resp_ready(resp_ready), .resp_data(d_resp_data[1]), .mem_req_valid(d_mem_req_valid[1]),
        .mem_req_ready(mem_req_ready), .mem_req_addr(d_mem_req_addr[1]), .mem_req_we(d_mem_req_we[1]),
        .mem_req_wdata(d_mem_req_wdata[1]), .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(d_mem_resp_ready[1]), .mem_resp_data(mem_resp_data), .busy(d_busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input int i);
        if (req_valid == 2'b01) return 1'b0;
        if (req_valid == 2'b10) return 1'b1;
        return (i == 0) ? !m_last[i] : 1'b0;
    endfunction

    task automatic check_all();
        logic [1:0]  e_rr, e_rv;
        logic [31:0] e_rd;
        bit          e_mrv, e_mrr;
        bit          g;
        for (int i = 0; i < 2; i++) begin
            e_rr = 2'b00; e_rv = 2'b00; e_rd = 32'h0; e_mrv = 1'b0; e_mrr = 1'b0;
            if (m_phase[i] == 0 && req_valid != 2'b00) begin
                g = pick(i);
                e_rr[g] = 1'b1;
            end
            if (m_phase[i] == 1) e_mrv = 1'b1;
            if (m_phase[i] == 2) begin
                e_rv[m_owner[i]] = mem_resp_valid;
                e_mrr = resp_ready[m_owner[i]];
                e_rd = mem_resp_data;
            end
            chk($sformatf("u%0d req_ready", i), d_req_ready[i], e_rr);
            chk($sformatf("u%0d resp_valid", i), d_resp_valid[i], e_rv);
            chk($sformatf("u%0d resp_data", i), d_resp_data[i], e_rd);
            chk($sformatf("u%0d mem_req_valid", i), d_mem_req_valid[i], e_mrv);
            chk($sformatf("u%0d mem_req_addr", i), d_mem_req_addr[i], m_addr[i]);
            chk($sformatf("u%0d mem_req_we", i), d_mem_req_we[i], m_we[i]);
            chk($sformatf("u%0d mem_req_wdata", i), d_mem_req_wdata[i], m_wdata[i]);
            chk($sformatf("u%0d mem_resp_ready", i), d_mem_resp_ready[i], e_mrr);
            chk($sformatf("u%0d busy", i), d_busy[i], m_phase[i] != 0);
        end
        for (int k = 0; k < 2; k++) begin
            if (d_req_ready[0][k] && req_valid[k]) gq0.push_back(k);
            if (d_req_ready[1][k] && req_valid[k]) gq1.push_back(k);
        end
        if (d_mem_req_valid[0] && mem_req_ready) aq0.push_back(d_mem_req_addr[0]);
        if (d_mem_req_valid[1] && mem_req_ready) aq1.push_back(d_mem_req_addr[1]);
    endtask

    task automatic advance();
        bit g;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_phase[i] = 0; m_owner[i] = 1'b0; m_last[i] = 1'b1;
                m_addr[i] = 32'h0; m_we[i] = 1'b0; m_wdata[i] = 32'h0;
            end else if (m_phase[i] == 0) begin
                if (req_valid != 2'b00) begin
                    g = pick(i);
                    m_owner[i] = g;
                    m_addr[i]  = g ? req_addr1 : req_addr0;
                    m_wdata[i] = g ? req_wdata1 : req_wdata0;
                    m_we[i]    = req_we[g];
                    m_phase[i] = 1;
                end
            end else if (m_phase[i] == 1) begin
                if (mem_req_ready) m_phase[i] = 2;
            end else if (mem_resp_valid && resp_ready[m_owner[i]]) begin
                m_last[i]  = m_owner[i];
                m_phase[i] = 0;
            end
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic commit();
        check_all();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        to_sample();
        commit();
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00; req_we = 2'b00; resp_ready = 2'b00;
        req_addr0 = 32'h0; req_addr1 = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        gq0.delete(); gq1.delete(); aq0.delete(); aq1.delete();
    endtask

    initial begin
        int n_p1;
        int exp_rr[4];
        logic [31:0] exp_a[4];
        exp_rr = '{0, 1, 0, 1};
        exp_a  = '{32'h100, 32'h4, 32'h100, 32'h4};

        do_reset();
        chk("reset busy", d_busy[0], 1'b0);

        // Single read from port 1
        req_valid = 2'b10; req_addr1 = 32'h8;
        to_sample();
        chk("rd req_ready", d_req_ready[0], 2'b10);
        commit();
        req_valid = 2'b00; mem_req_ready = 1'b1;
        to_sample();
        chk("rd mem_req_addr", d_mem_req_addr[0], 32'h8);
        commit();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h13; resp_ready = 2'b11;
        to_sample();
        chk("rd resp_valid", d_resp_valid[0], 2'b10);
        chk("rd resp_data", d_resp_data[0], 32'h13);
        commit();
        mem_resp_valid = 1'b0;
        tick();
        chk("rd grant count", gq0.size(), 1);

        // Both ports valid from reset
        do_reset();
        req_valid = 2'b11; req_addr0 = 32'h100; req_addr1 = 32'h4;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; resp_ready = 2'b11; mem_resp_data = 32'h55;
        for (int c = 0; c < 12; c++) tick();
        chk("rr grant count", gq0.size(), 4);
        chk("fp grant count", gq1.size(), 4);
        n_p1 = 0;
        for (int n = 0; n < gq1.size(); n++) if (gq1[n] != 0) n_p1++;
        chk("fp port1 grants", n_p1, 0);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("rr grant %0d", n), (n < gq0.size()) ? gq0[n] : -1, exp_rr[n]);
            chk($sformatf("rr addr %0d", n), (n < aq0.size()) ? aq0[n] : 32'hFFFF_FFFF, exp_a[n]);
        end

        // Downstream backpressure in ISSUE
        do_reset();
        req_valid = 2'b01; req_addr0 = 32'h40; req_we = 2'b01; req_wdata0 = 32'hA5A5_0001;
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            to_sample();
            chk("bp addr stable", d_mem_req_addr[0], 32'h40);
            chk("bp wdata stable", d_mem_req_wdata[0], 32'hA5A5_0001);
            commit();
        end
        mem_req_ready = 1'b1;
        to_sample();
        chk("bp addr final", d_mem_req_addr[0], 32'h40);
        commit();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; resp_ready = 2'b11;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        chk("bp handshakes", aq0.size(), 1);

        // Port 0 write with a stalled response consumer
        do_reset();
        req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'h200; req_wdata0 = 32'hDEADBEEF;
        tick();
        req_valid = 2'b00; mem_req_ready = 1'b1;
        to_sample();
        chk("wr mem_req_we", d_mem_req_we[0], 1'b1);
        chk("wr mem_req_wdata", d_mem_req_wdata[0], 32'hDEADBEEF);
        commit();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; resp_ready = 2'b00;
        for (int c = 0; c < 2; c++) begin
            to_sample();
            chk("wr mem_resp_ready low", d_mem_resp_ready[0], 1'b0);
            chk("wr busy held", d_busy[0], 1'b1);
            commit();
        end
        resp_ready = 2'b01;
        to_sample();
        chk("wr mem_resp_ready", d_mem_resp_ready[0], 1'b1);
        commit();
        mem_resp_valid = 1'b0;
        to_sample();
        chk("wr busy clear", d_busy[0], 1'b0);
        commit();

        // Reset while waiting for a read response, then a tie
        req_valid = 2'b10; req_we = 2'b00; req_addr1 = 32'h30;
        tick();
        req_valid = 2'b00; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        to_sample();
        chk("rst busy", d_busy[0], 1'b0);
        chk("rst mem_req_valid", d_mem_req_valid[0], 1'b0);
        chk("rst resp_valid", d_resp_valid[0], 2'b00);
        commit();
        req_valid = 2'b11;
        to_sample();
        chk("rst tie rr", d_req_ready[0], 2'b01);
        chk("rst tie fp", d_req_ready[1], 2'b01);
        commit();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            req_valid      = 2'($urandom_range(0, 3));
            req_we         = 2'($urandom_range(0, 3));
            req_addr0      = $urandom; req_addr1 = $urandom;
            req_wdata0     = $urandom; req_wdata1 = $urandom;
            resp_ready     = 2'($urandom_range(0, 3));
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            mem_resp_valid = ($urandom_range(0, 2) != 0);
            mem_resp_data  = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
